uart_rx_ex: RTL and testbench
=============================

Name: uart_rx_ex

Overview:
- Next-generation UART receiver with an AXI4-Stream output.
- Adds over the current receiver:
  - runtime parity: none, even or odd;
  - 1 or 2 stop bits;
  - a 2-FF input synchroniser;
  - false-start rejection;
  - break detection;
  - per-byte error tags on tuser.
- Sits beside the existing transmitter under the UART top and feeds the command parser.

Parameters:
- DATA_WIDTH, 8, payload bits per frame; legal range 5..9.
- SYNC_STAGES, 2, rxd synchroniser depth; legal range 2..4.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset: synchronous, active-low (0 = reset).
- output_axis_tdata  output  DATA_WIDTH  received payload, LSB-first on the line.
- output_axis_tuser  output  3  error tag: [0] frame_err, [1] parity_err, [2] break.
- output_axis_tvalid  output  1  word valid.
- output_axis_tready  input  1  consumer ready.
- rxd  input  1  asynchronous serial input, idle high.
- prescale  input  16  bit period = prescale*8 clk cycles; 0 is treated as 1.
- parity_mode  input  2  00 none, 01 even, 10 odd, 11 none.
- stop_bits  input  1  0 = one stop bit, 1 = two stop bits.
- busy  output  1  high from start-bit detect until return to IDLE.
- overrun_error  output  1  one-cycle pulse.
- frame_error  output  1  one-cycle pulse.
- parity_error  output  1  one-cycle pulse.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state IDLE; tdata=0, tuser=0, tvalid=0; busy=0; all error pulses 0.
  - Synchroniser flops load 1.
  - Applies mid-frame too: the partial frame is discarded and no output is produced.
- Timing:
  - Input is sampled only after SYNC_STAGES flops.
  - Bit timer is a 19-bit down-counter; half bit = prescale*4, full bit = prescale*8.
- Config (prescale, parity_mode, stop_bits) is latched at start detect and held for the whole frame.
- IDLE: a synced rxd of 0 sets busy=1, loads the half-bit timer and enters START.
- START, at timer expiry:
  - sample 0 -> DATA with the full-bit timer loaded;
  - sample 1 -> false start: back to IDLE, busy=0, nothing emitted.
- DATA:
  - Samples DATA_WIDTH bits at each full-bit expiry, shifting in LSB-first.
  - Keeps a running XOR of sampled bits and an all-zero flag.
  - Next state is PARITY if parity is enabled, else STOP1.
- PARITY: at expiry, parity_err is set if:
  - even mode: XOR of data^pbit = 1;
  - odd mode: XOR of data^pbit = 0.
- STOP1: at expiry, frame_err = (sample==0).
  - break = frame_err AND all data bits 0 AND (parity disabled OR parity bit 0).
  - break -> BREAK_WAIT.
  - otherwise -> STOP2 if stop_bits=1, else EMIT.
- STOP2: at expiry, a sample of 0 sets frame_err; then EMIT.
- EMIT (1 cycle):
  - Load tdata/tuser and set tvalid=1.
  - Pulse frame_error / parity_error for one cycle as applicable.
  - Go to IDLE, busy=0.
- BREAK_WAIT:
  - Emit with tdata=0, tuser=3'b101 (parity_err bit per computation), pulse frame_error.
  - busy stays 1 until synced rxd=1, then IDLE.
  - A long break produces exactly one word.
- Latency: tvalid rises 1 cycle after the last stop-bit sample.
- Handshake:
  - tvalid clears on the cycle after tvalid&tready.
  - tdata/tuser are held stable while tvalid=1 and tready=0.
- Overrun: EMIT while tvalid=1 and tready=0:
  - the new word overwrites tdata/tuser;
  - tvalid stays 1;
  - overrun_error pulses for 1 cycle.
- Simultaneous EMIT and a handshake on the old word: not an overrun; the new word is valid next cycle.
- Back-to-back frames: a start bit is accepted on the first IDLE cycle after EMIT.

Decomposition:
- Shared package uart_pkg:
  - PARITY_NONE/EVEN/ODD constants;
  - tuser bit indices (TUSER_FRAME=0, TUSER_PARITY=1, TUSER_BREAK=2);
  - state encoding.
- One sub-module uart_sync: parametrised SYNC_STAGES flop chain with reset value 1. It is reused later by the transmitter's CTS input.

Test Plan:
- prescale=1, 8N1, send 0x55 with tready=1 -> tdata=0x55, tuser=0, tvalid 1 cycle; tvalid rises 1 cycle after the stop-bit sample (80 synced cycles after start edge plus 1); busy=0 afterwards.
- parity_mode=01, send 0xA3 with parity bit 0 -> tuser=0; resend with parity bit 1 -> tuser=3'b010, parity_error pulses once; parity_mode=10 with parity bit 1 -> tuser=0.
- rxd low for 2 cycles then high, prescale=4 -> no tvalid, busy returns to 0 after 16 cycles, no error pulses.
- stop_bits=1, second stop bit driven 0 on 0x3C -> tdata=0x3C, tuser=3'b001, frame_error pulse; the same frame with stop_bits=0 -> tuser=0.
- rxd held low 20 bit periods, then high -> exactly one word tdata=0, tuser=3'b101; busy stays high until rxd returns high.
- tready=0, send 0x11 then 0x22 -> tdata=0x22, one overrun_error pulse; rst=0 mid-third frame -> tvalid=0, busy=0, no word after release.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, tuser bit positions, receiver state
// encoding and the bit-period helper used to load the bit timer.
package uart_pkg;

    localparam logic [1:0] PARITY_NONE = 2'b00;
    localparam logic [1:0] PARITY_EVEN = 2'b01;
    localparam logic [1:0] PARITY_ODD  = 2'b10;

    localparam int TUSER_FRAME  = 0;
    localparam int TUSER_PARITY = 1;
    localparam int TUSER_BREAK  = 2;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_DATA       = 3'd2,
        ST_PARITY     = 3'd3,
        ST_STOP1      = 3'd4,
        ST_STOP2      = 3'd5,
        ST_EMIT       = 3'd6,
        ST_BREAK_WAIT = 3'd7
    } uart_state_e;

    // True when the mode carries a parity bit on the line (11 means none).
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PARITY_EVEN) || (mode == PARITY_ODD);
    endfunction

    // Timer reload value: the timer expires when it reaches zero, so load N-1.
    // A prescale of 0 behaves as 1.
    function automatic logic [18:0] bit_time(input logic [15:0] ps, input logic half);
        logic [15:0] eff;
        eff = (ps == 16'd0) ? 16'd1 : ps;
        if (half) begin
            return {1'b0, eff, 2'b00} - 19'd1;
        end else begin
            return {eff, 3'b000} - 19'd1;
        end
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for an asynchronous, idle-high serial line.
// Flops reset to 1 so a reset never looks like a start bit.
module uart_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_chain;

    // Shift the raw input through the flop chain.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_chain <= {SYNC_STAGES{1'b1}};
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_ex.sv
// UART receiver with AXI4-Stream output, runtime parity, 1/2 stop bits,
// false-start rejection, break detection and per-word error tags on tuser.
module uart_rx_ex
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] output_axis_tdata,
    output logic [2:0]            output_axis_tuser,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    input  logic                  rxd,
    input  logic [15:0]           prescale,
    input  logic [1:0]            parity_mode,
    input  logic                  stop_bits,
    output logic                  busy,
    output logic                  overrun_error,
    output logic                  frame_error,
    output logic                  parity_error
);

    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

    logic                  w_rxd;
    uart_state_e           r_state;
    uart_state_e           w_state_next;
    logic [18:0]           r_timer;
    logic [15:0]           r_prescale;
    logic [1:0]            r_parity_mode;
    logic                  r_stop2;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [3:0]            r_bitcnt;
    logic                  r_xor;
    logic                  r_allzero;
    logic                  r_pbit;
    logic                  r_perr;
    logic                  r_ferr;
    logic                  r_brk_sent;
    logic                  w_expire;
    logic                  w_par_en;
    logic                  w_brk;
    logic                  w_emit;
    logic [DATA_WIDTH-1:0] w_out_data;
    logic [2:0]            w_out_user;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic [2:0]            r_tuser;
    logic                  r_tvalid;
    logic                  r_busy;
    logic                  r_ovr;
    logic                  r_ferr_p;
    logic                  r_perr_p;

    uart_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rxd),
        .o_q (w_rxd)
    );

    assign w_expire = (r_timer == 19'd0);
    assign w_par_en = parity_enabled(r_parity_mode);
    // A break is a framing error on an all-zero frame (parity bit included).
    assign w_brk    = ~w_rxd & r_allzero & (~w_par_en | ~r_pbit);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and the word presented to the output stage.
    always_comb begin
        w_state_next = r_state;
        w_emit       = 1'b0;
        w_out_data   = {DATA_WIDTH{1'b0}};
        w_out_user   = 3'b000;
        case (r_state)
            ST_IDLE: begin
                if (!w_rxd) w_state_next = ST_START;
                else        w_state_next = ST_IDLE;
            end
            ST_START: begin
                if (w_expire) w_state_next = w_rxd ? ST_IDLE : ST_DATA;
                else          w_state_next = ST_START;
            end
            ST_DATA: begin
                if (w_expire && (r_bitcnt == LAST_BIT)) w_state_next = w_par_en ? ST_PARITY : ST_STOP1;
                else                                    w_state_next = ST_DATA;
            end
            ST_PARITY: begin
                if (w_expire) w_state_next = ST_STOP1;
                else          w_state_next = ST_PARITY;
            end
            ST_STOP1: begin
                if (w_expire) begin
                    if (w_brk)        w_state_next = ST_BREAK_WAIT;
                    else if (r_stop2) w_state_next = ST_STOP2;
                    else              w_state_next = ST_EMIT;
                end else begin
                    w_state_next = ST_STOP1;
                end
            end
            ST_STOP2: begin
                if (w_expire) w_state_next = ST_EMIT;
                else          w_state_next = ST_STOP2;
            end
            ST_EMIT: begin
                w_emit                   = 1'b1;
                w_out_data               = r_shift;
                w_out_user[TUSER_FRAME]  = r_ferr;
                w_out_user[TUSER_PARITY] = r_perr;
                w_out_user[TUSER_BREAK]  = 1'b0;
                w_state_next             = ST_IDLE;
            end
            ST_BREAK_WAIT: begin
                // Only the first cycle of a break produces a word.
                if (!r_brk_sent) begin
                    w_emit                   = 1'b1;
                    w_out_user[TUSER_FRAME]  = 1'b1;
                    w_out_user[TUSER_PARITY] = r_perr;
                    w_out_user[TUSER_BREAK]  = 1'b1;
                end else begin
                    w_emit = 1'b0;
                end
                if (w_rxd) w_state_next = ST_IDLE;
                else       w_state_next = ST_BREAK_WAIT;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Bit timer, config latch, shift register and per-frame error tracking.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_timer       <= 19'd0;
            r_prescale    <= 16'd0;
            r_parity_mode <= 2'b00;
            r_stop2       <= 1'b0;
            r_shift       <= {DATA_WIDTH{1'b0}};
            r_bitcnt      <= 4'd0;
            r_xor         <= 1'b0;
            r_allzero     <= 1'b1;
            r_pbit        <= 1'b0;
            r_perr        <= 1'b0;
            r_ferr        <= 1'b0;
            r_brk_sent    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_rxd) begin
                        r_prescale    <= prescale;
                        r_parity_mode <= parity_mode;
                        r_stop2       <= stop_bits;
                        r_timer       <= bit_time(prescale, 1'b1);
                        r_shift       <= {DATA_WIDTH{1'b0}};
                        r_bitcnt      <= 4'd0;
                        r_xor         <= 1'b0;
                        r_allzero     <= 1'b1;
                        r_pbit        <= 1'b0;
                        r_perr        <= 1'b0;
                        r_ferr        <= 1'b0;
                        r_brk_sent    <= 1'b0;
                    end else begin
                        r_timer <= r_timer;
                    end
                end
                ST_START: begin
                    if (w_expire) r_timer <= bit_time(r_prescale, 1'b0);
                    else          r_timer <= r_timer - 19'd1;
                end
                ST_DATA: begin
                    if (w_expire) begin
                        r_shift   <= {w_rxd, r_shift[DATA_WIDTH-1:1]};
                        r_xor     <= r_xor ^ w_rxd;
                        r_allzero <= r_allzero & ~w_rxd;
                        r_bitcnt  <= r_bitcnt + 4'd1;
                        r_timer   <= bit_time(r_prescale, 1'b0);
                    end else begin
                        r_timer <= r_timer - 19'd1;
                    end
                end
                ST_PARITY: begin
                    if (w_expire) begin
                        r_pbit  <= w_rxd;
                        r_perr  <= (r_parity_mode == PARITY_EVEN) ? (r_xor ^ w_rxd) : ~(r_xor ^ w_rxd);
                        r_timer <= bit_time(r_prescale, 1'b0);
                    end else begin
                        r_timer <= r_timer - 19'd1;
                    end
                end
                ST_STOP1: begin
                    if (w_expire) begin
                        r_ferr  <= ~w_rxd;
                        r_timer <= bit_time(r_prescale, 1'b0);
                    end else begin
                        r_timer <= r_timer - 19'd1;
                    end
                end
                ST_STOP2: begin
                    if (w_expire) r_ferr  <= r_ferr | ~w_rxd;
                    else          r_timer <= r_timer - 19'd1;
                end
                ST_BREAK_WAIT: begin
                    r_brk_sent <= 1'b1;
                end
                default: begin
                    r_timer <= r_timer;
                end
            endcase
        end
    end

    // AXI-Stream output register, handshake, overrun and error pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tdata  <= {DATA_WIDTH{1'b0}};
            r_tuser  <= 3'b000;
            r_tvalid <= 1'b0;
            r_busy   <= 1'b0;
            r_ovr    <= 1'b0;
            r_ferr_p <= 1'b0;
            r_perr_p <= 1'b0;
        end else begin
            r_busy <= (w_state_next != ST_IDLE);
            if (w_emit) begin
                r_tdata  <= w_out_data;
                r_tuser  <= w_out_user;
                r_tvalid <= 1'b1;
                r_ovr    <= r_tvalid & ~output_axis_tready;
                r_ferr_p <= w_out_user[TUSER_FRAME];
                r_perr_p <= w_out_user[TUSER_PARITY];
            end else begin
                r_ovr    <= 1'b0;
                r_ferr_p <= 1'b0;
                r_perr_p <= 1'b0;
                if (r_tvalid && output_axis_tready) r_tvalid <= 1'b0;
                else                                r_tvalid <= r_tvalid;
            end
        end
    end

    assign output_axis_tdata  = r_tdata;
    assign output_axis_tuser  = r_tuser;
    assign output_axis_tvalid = r_tvalid;
    assign busy               = r_busy;
    assign overrun_error      = r_ovr;
    assign frame_error        = r_ferr_p;
    assign parity_error       = r_perr_p;

endmodule

// File: tb/tb_uart_rx_ex.sv
// Self-checking bench for uart_rx_ex: a directed vector table, randomized
// frames against a frame-level reference model, and hand-written sequences
// for latency, false start, long break, overrun and mid-frame reset.
module tb_uart_rx_ex;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  tdata;
    logic [2:0]  tuser;
    logic        tvalid;
    logic        tready;
    logic        rxd;
    logic [15:0] prescale;
    logic [1:0]  parity_mode;
    logic        stop_bits;
    logic        busy;
    logic        ovr;
    logic        ferr;
    logic        perr;

    int n_checks = 0;
    int n_errors = 0;

    // Monitor state (written only by the monitor process).
    int         cyc = 0;
    int         n_hs = 0, n_tv_hi = 0, n_rise = 0, last_rise = 0;
    int         n_ferr = 0, n_perr = 0, n_ovr = 0;
    logic       prev_tv = 1'b0;
    logic [7:0] word_data [256];
    logic [2:0] word_user [256];

    typedef struct {
        logic [7:0]  d;
        logic [15:0] ps;
        logic [1:0]  pm;
        logic        pb, s1, s2, ns;
        logic [7:0]  exp_d;
        logic [2:0]  exp_u;
    } vec_t;

    vec_t vt [12];

    uart_rx_ex #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk                (clk),
        .rst                (rst),
        .output_axis_tdata  (tdata),
        .output_axis_tuser  (tuser),
        .output_axis_tvalid (tvalid),
        .output_axis_tready (tready),
        .rxd                (rxd),
        .prescale           (prescale),
        .parity_mode        (parity_mode),
        .stop_bits          (stop_bits),
        .busy               (busy),
        .overrun_error      (ovr),
        .frame_error        (ferr),
        .parity_error       (perr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record accepted words, tvalid activity and error pulses mid-cycle.
    always @(negedge clk) begin
        if (tvalid && tready) begin
            word_data[n_hs[7:0]] <= tdata;
            word_user[n_hs[7:0]] <= tuser;
            n_hs <= n_hs + 1;
        end
        if (tvalid && !prev_tv) begin
            n_rise    <= n_rise + 1;
            last_rise <= cyc;
        end
        if (tvalid) n_tv_hi <= n_tv_hi + 1;
        if (ferr)   n_ferr  <= n_ferr + 1;
        if (perr)   n_perr  <= n_perr + 1;
        if (ovr)    n_ovr   <= n_ovr + 1;
        prev_tv <= tvalid;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Frame-level reference: expected {tuser, tdata} from the line contents.
    function automatic logic [10:0] model(input logic [7:0] d, input logic [1:0] pm,
                                          input logic pb, input logic s1, input logic s2,
                                          input logic ns);
        logic par_en, p_err, f_err, brk;
        int   ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        par_en = (pm == 2'b01) || (pm == 2'b10);
        if (pm == 2'b01)      p_err = ((ones + int'(pb)) % 2) == 1;
        else if (pm == 2'b10) p_err = ((ones + int'(pb)) % 2) == 0;
        else                  p_err = 1'b0;
        brk   = !s1 && (d == 8'h00) && (!par_en || !pb);
        f_err = !s1 || (ns && !s2);
        if (brk) return {1'b1, p_err, 1'b1, 8'h00};
        else     return {1'b0, p_err, f_err, d};
    endfunction

    // Drive one frame on rxd; returns with the line idle.
    task automatic send_frame(input logic [7:0] d, input logic [15:0] ps, input logic [1:0] pm,
                              input logic pb, input logic s1, input logic s2, input logic ns);
        int per;
        per         = (ps == 16'd0) ? 8 : int'(ps) * 8;
        prescale    = ps;
        parity_mode = pm;
        stop_bits   = ns;
        rxd = 1'b0;
        tick(per);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            tick(per);
        end
        if (pm == 2'b01 || pm == 2'b10) begin
            rxd = pb;
            tick(per);
        end
        rxd = s1;
        tick(per);
        if (ns) begin
            rxd = s2;
            tick(per);
        end
        rxd = 1'b1;
    endtask

    task automatic run_vector(input vec_t v, input string tag);
        int hs0, f0, p0, per;
        hs0 = n_hs; f0 = n_ferr; p0 = n_perr;
        per = (v.ps == 16'd0) ? 8 : int'(v.ps) * 8;
        send_frame(v.d, v.ps, v.pm, v.pb, v.s1, v.s2, v.ns);
        tick(3 * per);
        chk({tag, " words"}, n_hs - hs0, 1);
        chk({tag, " tdata"}, word_data[hs0[7:0]], v.exp_d);
        chk({tag, " tuser"}, word_user[hs0[7:0]], v.exp_u);
        chk({tag, " frame_error pulses"}, n_ferr - f0, int'(v.exp_u[0]));
        chk({tag, " parity_error pulses"}, n_perr - p0, int'(v.exp_u[1]));
    endtask

    initial begin
        int          s0, tv0, hs0, f0, p0, o0, r0, bad, bcnt;
        logic [10:0] m;
        vec_t        rv;

        rst = 1'b0; rxd = 1'b1; tready = 1'b1;
        prescale = 16'd1; parity_mode = 2'b00; stop_bits = 1'b0;

        //                d      ps      pm     pb    s1    s2    ns    exp_d  exp_u
        vt[0]  = '{8'h55, 16'd1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h55, 3'b000};
        vt[1]  = '{8'hA3, 16'd1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA3, 3'b000};
        vt[2]  = '{8'hA3, 16'd1, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA3, 3'b010};
        vt[3]  = '{8'hA3, 16'd1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA3, 3'b000};
        vt[4]  = '{8'h3C, 16'd1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 3'b001};
        vt[5]  = '{8'h3C, 16'd1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 3'b000};
        vt[6]  = '{8'h00, 16'd1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'b101};
        vt[7]  = '{8'h00, 16'd2, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'b111};
        vt[8]  = '{8'h80, 16'd1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h80, 3'b001};
        vt[9]  = '{8'hC5, 16'd0, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 8'hC5, 3'b000};
        vt[10] = '{8'h0F, 16'd3, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 8'h0F, 3'b000};
        vt[11] = '{8'h00, 16'd1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'b011};

        // Reset state.
        tick(4);
        chk("reset tvalid", tvalid, 0);
        chk("reset tdata", tdata, 0);
        chk("reset tuser", tuser, 0);
        chk("reset busy", busy, 0);
        chk("reset pulses", {ovr, ferr, perr}, 0);
        rst = 1'b1;
        tick(4);
        chk("idle busy", busy, 0);

        // 8N1 0x55 at prescale 1: latency and single-cycle tvalid.
        s0 = cyc; tv0 = n_tv_hi; hs0 = n_hs;
        send_frame(8'h55, 16'd1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(16);
        chk("latency rise-start", last_rise - s0, 80);
        chk("latency tvalid width", n_tv_hi - tv0, 1);
        chk("latency tdata", word_data[hs0[7:0]], 8'h55);
        chk("latency busy after", busy, 0);

        // Directed vector table.
        for (int i = 0; i < 12; i++) run_vector(vt[i], $sformatf("vec%0d", i));

        // Randomized frames against the reference model.
        for (int i = 0; i < 12; i++) begin
            rv.d  = 8'($urandom);
            rv.ps = 16'($urandom_range(0, 3));
            rv.pm = 2'($urandom_range(0, 3));
            rv.pb = 1'($urandom);
            rv.s1 = ($urandom_range(0, 4) != 0);
            rv.s2 = ($urandom_range(0, 4) != 0);
            rv.ns = 1'($urandom);
            m = model(rv.d, rv.pm, rv.pb, rv.s1, rv.s2, rv.ns);
            rv.exp_d = m[7:0];
            rv.exp_u = m[10:8];
            run_vector(rv, $sformatf("rand%0d", i));
        end

        // False start: 2 low cycles at prescale 4.
        prescale = 16'd4; parity_mode = 2'b00; stop_bits = 1'b0;
        tick(2);
        r0 = n_rise; f0 = n_ferr; p0 = n_perr; o0 = n_ovr; bcnt = 0;
        rxd = 1'b0;
        tick(2);
        rxd = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (busy) bcnt++;
        end
        chk("false start busy cycles", bcnt, 16);
        chk("false start no word", n_rise - r0, 0);
        chk("false start no pulses", (n_ferr - f0) + (n_perr - p0) + (n_ovr - o0), 0);

        // Long break: 20 bit periods low at prescale 1.
        prescale = 16'd1;
        tick(2);
        hs0 = n_hs; bad = 0;
        rxd = 1'b0;
        for (int i = 0; i < 160; i++) begin
            tick(1);
            if (i >= 3 && !busy) bad++;
        end
        chk("break busy held", bad, 0);
        rxd = 1'b1;
        tick(1);
        chk("break busy at release", busy, 1);
        tick(6);
        chk("break busy cleared", busy, 0);
        chk("break words", n_hs - hs0, 1);
        chk("break tdata", word_data[hs0[7:0]], 8'h00);
        chk("break tuser", word_user[hs0[7:0]], 3'b101);

        // Overrun with tready low, then reset in the middle of a third frame.
        tready = 1'b0;
        o0 = n_ovr;
        send_frame(8'h11, 16'd1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(16);
        chk("ovr first tvalid", tvalid, 1);
        chk("ovr first tdata", tdata, 8'h11);
        send_frame(8'h22, 16'd1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(16);
        chk("ovr tdata", tdata, 8'h22);
        chk("ovr tvalid held", tvalid, 1);
        chk("ovr pulses", n_ovr - o0, 1);
        rxd = 1'b0;
        tick(8);
        rxd = 1'b1;
        tick(24);
        chk("mid-frame busy", busy, 1);
        r0 = n_rise;
        rst = 1'b0;
        tick(2);
        chk("mid reset tvalid", tvalid, 0);
        chk("mid reset busy", busy, 0);
        rst = 1'b1;
        tick(64);
        chk("post reset tvalid", tvalid, 0);
        chk("post reset busy", busy, 0);
        chk("post reset no word", n_rise - r0, 0);
        tready = 1'b1;
        tick(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
